// File: rtl/multi_core_rst_seq.sv
// -----------------------------------------------------------------------------
// multi_core_rst_seq
//
// Power-on reset sequencer for a multi-core cluster, plus serialized per-core
// soft resets once the power-on sequence has completed.
//
// Power-on: after rst falls, sys_rstn is held low for HOLD_CYCLES edges. The
// enable mask is captured on the edge sys_rstn rises. Each enabled core is then
// released in ascending index order, STAGGER_CYCLES edges apart. Disabled cores
// stay in reset. seq_done rises with the last release, or together with
// sys_rstn if no core is enabled.
//
// Soft reset: once seq_done is high, requests from enabled cores are queued in
// a pending mask. One core at a time is held low for SOFT_CYCLES edges. The
// lowest pending index is served first. There is one idle edge between
// consecutive soft resets.
//
// Ports
//   clk           in   single clock, all state changes on posedge
//   rst           in   synchronous active-high reset
//   core_en       in   [NUM_CORES] cores released by the power-on sequence
//   soft_rst_req  in   [NUM_CORES] per-core soft-reset request, sampled each edge
//   sys_rstn      out  active-low system/interconnect reset
//   core_rstn     out  [NUM_CORES] active-low per-core resets
//   seq_done      out  power-on sequence complete
//   busy          out  soft reset active or pending
// -----------------------------------------------------------------------------
module multi_core_rst_seq #(
  parameter int NUM_CORES      = 2,
  parameter int HOLD_CYCLES    = 100,
  parameter int STAGGER_CYCLES = 16,
  parameter int SOFT_CYCLES    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CORES-1:0] core_en,
  input  logic [NUM_CORES-1:0] soft_rst_req,
  output logic                 sys_rstn,
  output logic [NUM_CORES-1:0] core_rstn,
  output logic                 seq_done,
  output logic                 busy
);

  localparam logic [15:0] HOLD_W    = 16'(HOLD_CYCLES);
  localparam logic [15:0] STAGGER_W = 16'(STAGGER_CYCLES);
  localparam logic [15:0] SOFT_W    = 16'(SOFT_CYCLES);

  typedef enum logic [1:0] {HOLD, STAGGER, RUN} state_e;

  state_e               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d, cnt_inc;
  logic [NUM_CORES-1:0] en_q, en_d;          // mask captured at sys_rstn release
  logic [NUM_CORES-1:0] rem_q, rem_d;        // enabled cores not yet released
  logic [NUM_CORES-1:0] pend_q, pend_d;      // queued soft-reset requests
  logic [NUM_CORES-1:0] act_q, act_d;        // one-hot core currently in soft reset
  logic [NUM_CORES-1:0] core_rstn_q, core_rstn_d;
  logic                 sys_rstn_q, sys_rstn_d;
  logic                 seq_done_q, seq_done_d;
  logic                 busy_q, busy_d;
  logic [NUM_CORES-1:0] rel, sel, req_eff;
  logic                 hold_hit, stag_hit, soft_hit, last_rel;

  // One-hot of the lowest set bit. The scan runs downward so the lowest set
  // bit is the one that remains.
  function automatic logic [NUM_CORES-1:0] lowest_bit(input logic [NUM_CORES-1:0] v);
    logic [NUM_CORES-1:0] r;
    r = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // The shared counter saturates instead of wrapping.
  assign cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign hold_hit = (cnt_inc == HOLD_W);
  assign stag_hit = (cnt_inc == STAGGER_W);
  assign soft_hit = (cnt_inc == SOFT_W);
  assign rel      = lowest_bit(rem_q);
  assign last_rel = ((rem_q & ~rel) == '0);
  assign sel      = lowest_bit(pend_q);
  // Requests for a core that is already pending or already in reset merge away.
  assign req_eff  = soft_rst_req & en_q & ~pend_q & ~act_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= HOLD;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      HOLD:    if (hold_hit) state_d = (core_en == '0) ? RUN : STAGGER;
      STAGGER: if (rem_q == '0 || (stag_hit && last_rel)) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = HOLD;
    endcase
  end

  // Next values of the counter, the masks and the registered outputs
  always_comb begin
    cnt_d       = cnt_q;
    en_d        = en_q;
    rem_d       = rem_q;
    pend_d      = pend_q;
    act_d       = act_q;
    core_rstn_d = core_rstn_q;
    sys_rstn_d  = sys_rstn_q;
    seq_done_d  = seq_done_q;
    busy_d      = busy_q;
    case (state_q)
      HOLD: begin
        cnt_d = cnt_inc;
        if (hold_hit) begin
          cnt_d      = '0;
          sys_rstn_d = 1'b1;
          en_d       = core_en;
          rem_d      = core_en;
          if (core_en == '0) seq_done_d = 1'b1;
        end
      end
      STAGGER: begin
        cnt_d = cnt_inc;
        if (stag_hit) begin
          cnt_d       = '0;
          core_rstn_d = core_rstn_q | rel;
          rem_d       = rem_q & ~rel;
          if (last_rel) seq_done_d = 1'b1;
        end
      end
      RUN: begin
        if (act_q != '0) begin
          cnt_d = cnt_inc;
          if (soft_hit) begin
            cnt_d = '0;
            act_d = '0;
          end
        end else if (pend_q != '0) begin
          // The idle edge after a release comes from testing the registered
          // act_q, so a new selection can only happen one edge later.
          act_d  = sel;
          pend_d = pend_q & ~sel;
          cnt_d  = '0;
        end
        pend_d      = pend_d | req_eff;
        core_rstn_d = en_q & ~act_d;
        busy_d      = (pend_d != '0) || (act_d != '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      en_q        <= '0;
      rem_q       <= '0;
      pend_q      <= '0;
      act_q       <= '0;
      core_rstn_q <= '0;
      sys_rstn_q  <= 1'b0;
      seq_done_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      en_q        <= en_d;
      rem_q       <= rem_d;
      pend_q      <= pend_d;
      act_q       <= act_d;
      core_rstn_q <= core_rstn_d;
      sys_rstn_q  <= sys_rstn_d;
      seq_done_q  <= seq_done_d;
      busy_q      <= busy_d;
    end
  end

  assign sys_rstn  = sys_rstn_q;
  assign core_rstn = core_rstn_q;
  assign seq_done  = seq_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_multi_core_rst_seq.sv
// Bench for multi_core_rst_seq with four cores and the default timing.
// A timeline model (edge number since rst fell, precomputed release edges and
// a pending set with soft-reset end times) predicts every output. A negedge
// process compares the DUT against the model on every cycle. Directed phases
// add literal checks at the key edges.
module tb_multi_core_rst_seq;

  localparam int NC   = 4;
  localparam int HOLD = 100;
  localparam int STAG = 16;
  localparam int SOFT = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NC-1:0] core_en = '0;
  logic [NC-1:0] soft_rst_req = '0;
  logic          sys_rstn;
  logic [NC-1:0] core_rstn;
  logic          seq_done;
  logic          busy;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 0;
  bit rnd_req  = 0;

  multi_core_rst_seq #(
    .NUM_CORES(NC), .HOLD_CYCLES(HOLD), .STAGGER_CYCLES(STAG), .SOFT_CYCLES(SOFT)
  ) dut (
    .clk(clk), .rst(rst), .core_en(core_en), .soft_rst_req(soft_rst_req),
    .sys_rstn(sys_rstn), .core_rstn(core_rstn), .seq_done(seq_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int            m_n = 0;           // edges since rst fell
  logic [NC-1:0] m_cap = '0;        // captured enable mask
  int            m_rel[NC];         // release edge for each enabled core
  int            m_done_edge = 0;
  logic [NC-1:0] m_pend = '0;
  int            m_act = -1;        // core in soft reset, -1 when none
  int            m_act_end = 0;     // edge on which that core is released

  function automatic int lowest_idx(input logic [NC-1:0] v);
    for (int i = 0; i < NC; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    logic          was_done;
    logic [NC-1:0] actmask, newreq;
    int            k;
    if (rst) begin
      m_n = 0; m_cap = '0; m_pend = '0; m_act = -1; m_done_edge = 0;
    end else begin
      was_done = (m_n >= HOLD) && (m_n >= m_done_edge);
      m_n = m_n + 1;
      if (m_n == HOLD) begin
        m_cap = core_en;
        k = 0;
        for (int i = 0; i < NC; i++) begin
          m_rel[i] = 0;
          if (m_cap[i]) begin
            k++;
            m_rel[i] = HOLD + k * STAG;
          end
        end
        m_done_edge = HOLD + k * STAG;
      end
      if (was_done) begin
        actmask = '0;
        if (m_act >= 0) actmask[m_act] = 1'b1;
        newreq = soft_rst_req & m_cap & ~m_pend & ~actmask;
        if (m_act >= 0) begin
          if (m_n == m_act_end) m_act = -1;
        end else if (m_pend != '0) begin
          m_act = lowest_idx(m_pend);
          m_pend[m_act] = 1'b0;
          m_act_end = m_n + SOFT;
        end
        m_pend = m_pend | newreq;
      end
    end
  end

  function automatic logic [NC-1:0] exp_core();
    logic [NC-1:0] r;
    r = '0;
    for (int i = 0; i < NC; i++)
      r[i] = (m_n >= HOLD) && m_cap[i] && (m_n >= m_rel[i]) && (m_act != i);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model sys_rstn", 32'(sys_rstn), 32'(m_n >= HOLD));
      chk("model core_rstn", 32'(core_rstn), 32'(exp_core()));
      chk("model seq_done", 32'(seq_done), 32'((m_n >= HOLD) && (m_n >= m_done_edge)));
      chk("model busy", 32'(busy), 32'((m_pend != '0) || (m_act >= 0)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic edges(input int m);
    repeat (m) begin
      @(negedge clk);
      if (rnd_req) soft_rst_req = ($urandom_range(0, 3) == 0) ? NC'($urandom) : '0;
    end
  endtask

  task automatic do_reset(input logic [NC-1:0] en);
    rst = 1'b1;
    edges(2);
    rst = 1'b0;
    core_en = en;
  endtask

  initial begin
    edges(1);
    chk_en = 1;
    chk("reset sys_rstn", 32'(sys_rstn), 32'd0);
    chk("reset core_rstn", 32'(core_rstn), 32'd0);
    chk("reset seq_done/busy", 32'({seq_done, busy}), 32'd0);

    // Power-on with cores 0 and 1; early soft requests must be ignored.
    $display("phase: power-on core_en=0011");
    do_reset(4'b0011);
    rnd_req = 1;
    edges(99);  chk("sys_rstn before edge 100", 32'(sys_rstn), 32'd0);
    edges(1);   chk("sys_rstn at edge 100", 32'(sys_rstn), 32'd1);
    core_en = 4'b1100;                 // must be ignored after capture
    edges(15);  chk("cores at edge 115", 32'(core_rstn), 32'h0);
    edges(1);   chk("core0 at edge 116", 32'(core_rstn), 32'h1);
    edges(15);  chk("seq_done at edge 131", 32'(seq_done), 32'd0);
    edges(1);   chk("cores at edge 132", 32'(core_rstn), 32'h3);
    chk("seq_done at edge 132", 32'(seq_done), 32'd1);
    rnd_req = 0;
    soft_rst_req = '0;
    chk("busy after power-on", 32'(busy), 32'd0);

    // Two simultaneous soft requests
    $display("phase: soft reset req=0011");
    soft_rst_req = 4'b0011;
    edges(1); soft_rst_req = '0;
    chk("soft E busy", 32'(busy), 32'd1);
    chk("soft E cores", 32'(core_rstn), 32'h3);
    edges(1); chk("soft E+1 core0 low", 32'(core_rstn), 32'h2);
    edges(7); chk("soft E+8 core0 low", 32'(core_rstn), 32'h2);
    edges(1); chk("soft E+9 idle edge", 32'(core_rstn), 32'h3);
    chk("soft E+9 busy", 32'(busy), 32'd1);
    edges(1); chk("soft E+10 core1 low", 32'(core_rstn), 32'h1);
    edges(7); chk("soft E+17 busy", 32'(busy), 32'd1);
    edges(1); chk("soft E+18 cores", 32'(core_rstn), 32'h3);
    chk("soft E+18 busy", 32'(busy), 32'd0);

    // Repeated request while core0 is in soft reset merges
    $display("phase: merged soft request");
    soft_rst_req = 4'b0001;
    edges(1); soft_rst_req = '0;
    edges(1); chk("merge F+1 core0 low", 32'(core_rstn), 32'h2);
    soft_rst_req = 4'b0001;
    edges(1); soft_rst_req = '0;
    edges(7); chk("merge F+9 released", 32'(core_rstn), 32'h3);
    chk("merge F+9 busy", 32'(busy), 32'd0);
    edges(5); chk("merge F+14 no second pulse", 32'(core_rstn), 32'h3);

    // Mask 1010 with rst pulsed mid-stagger
    $display("phase: core_en=1010 with rst at edge 120");
    do_reset(4'b1010);
    edges(100); chk("1010 sys_rstn at 100", 32'(sys_rstn), 32'd1);
    edges(16);  chk("1010 core1 at 116", 32'(core_rstn), 32'h2);
    edges(3);   rst = 1'b1;
    edges(1);   chk("rst at 120 outputs", 32'({sys_rstn, core_rstn, seq_done, busy}), 32'd0);
    rst = 1'b0;
    edges(99);  chk("restart sys_rstn at 99", 32'(sys_rstn), 32'd0);
    edges(1);   chk("restart sys_rstn at 100", 32'(sys_rstn), 32'd1);
    edges(16);  chk("restart core1 at 116", 32'(core_rstn), 32'h2);
    edges(15);  chk("restart seq_done at 131", 32'(seq_done), 32'd0);
    edges(1);   chk("restart core3 at 132", 32'(core_rstn), 32'hA);
    chk("restart seq_done at 132", 32'(seq_done), 32'd1);

    // Empty mask
    $display("phase: core_en=0000");
    do_reset(4'b0000);
    edges(99);  chk("empty seq_done at 99", 32'({sys_rstn, seq_done}), 32'd0);
    edges(1);   chk("empty seq_done at 100", 32'({sys_rstn, seq_done}), 32'd3);
    chk("empty cores", 32'(core_rstn), 32'h0);
    soft_rst_req = 4'b1111;
    edges(3); soft_rst_req = '0;
    chk("empty soft ignored", 32'(busy), 32'd0);

    // Randomized rounds checked by the model
    for (int r = 0; r < 6; r++) begin
      logic [NC-1:0] en;
      int len;
      en  = NC'($urandom);
      len = $urandom_range(150, 600);
      $display("phase: random round %0d core_en=%b len=%0d", r, en, len);
      do_reset(en);
      rnd_req = 1;
      edges(len);
      rnd_req = 0;
      soft_rst_req = '0;
      edges(40);
    end

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
